// File: rtl/starflux_pkg.sv
// starflux_pkg: shared grid geometry, pixel colours and renderer state encoding
package starflux_pkg;
  localparam int GRID_W = 160;
  localparam int GRID_H = 120;
  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_PLAYER = 3'b010;
  localparam logic [2:0] COL_ENEMY  = 3'b100;
  localparam logic [2:0] COL_SHOT   = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;
endpackage

// File: rtl/column_shift_buffer.sv
// column_shift_buffer: holds one grid column and shifts it out LSB-first, one row per cycle
module column_shift_buffer #(
  parameter int W = 120
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         q0
);
  logic [W-1:0] r_q;
  // load wins over shift so a fresh column always starts at row 0
  always_ff @(posedge clock)
    if (reset) r_q <= '0;
    else if (load) r_q <= d;
    else if (shift) r_q <= r_q >> 1;
  assign q0 = r_q[0];
endmodule

// File: rtl/grid_renderer.sv
// grid_renderer: streams the projectile grid column by column to the VGA pixel port with ship overlays
module grid_renderer #(
  parameter int GRID_W = 160,
  parameter int GRID_H = 120
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [GRID_W*GRID_H-1:0] grid,
  input  logic [7:0]               user_x,
  input  logic [7:0]               enemy_x,
  output logic [7:0]               x,
  output logic [6:0]               y,
  output logic [2:0]               colour,
  output logic                     plot,
  output logic                     busy,
  output logic                     done
);
  import starflux_pkg::*;
  localparam int AW = $clog2(GRID_W*GRID_H);
  state_t r_state, w_next;
  logic [7:0] r_cx, r_ux, r_ex;
  logic [6:0] r_cy;
  logic [AW-1:0] w_base;
  logic w_q0, w_col_end, w_last_col, w_load, w_shift;
  assign w_base = AW'(int'(r_cx) * GRID_H);
  assign w_col_end = r_cy == 7'(GRID_H-1);
  assign w_last_col = r_cx == 8'(GRID_W-1);
  assign w_load = r_state == S_LOAD;
  assign w_shift = r_state == S_SCAN;
  column_shift_buffer #(.W(GRID_H)) u_buf (
    .clock(clock),
    .reset(reset),
    .load(w_load),
    .shift(w_shift),
    .d(grid[w_base +: GRID_H]),
    .q0(w_q0)
  );
  // state register, ship latches and column/row counters
  always_ff @(posedge clock)
    if (reset) begin
      r_state <= S_IDLE;
      r_cx <= '0;
      r_cy <= '0;
      r_ux <= '0;
      r_ex <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_ux <= user_x;
        r_ex <= enemy_x;
        r_cx <= '0;
      end
      if (r_state == S_LOAD) r_cy <= '0;
      if (r_state == S_SCAN) begin
        r_cy <= r_cy + 7'd1;
        if (w_col_end && !w_last_col) r_cx <= r_cx + 8'd1;
      end
    end
  // next state: one LOAD per column, DONE after the last row of the last column
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE) ? (start ? S_LOAD : S_IDLE) :
             (r_state == S_LOAD) ? S_SCAN :
             (r_state == S_SCAN) ? (w_col_end ? (w_last_col ? S_DONE : S_LOAD) : S_SCAN) :
             S_IDLE;
  end
  // pixel outputs come only from registers; ships override projectiles, player first
  always_comb begin
    x = r_cx;
    y = r_cy;
    plot = r_state == S_SCAN;
    busy = r_state != S_IDLE;
    done = r_state == S_DONE;
    colour = !plot ? COL_BLACK :
             (r_cx == r_ux && w_col_end) ? COL_PLAYER :
             (r_cx == r_ex && r_cy == 7'd0) ? COL_ENEMY :
             w_q0 ? COL_SHOT : COL_BLACK;
  end
endmodule

// File: tb/tb_grid_renderer.sv
// tb_grid_renderer: scoreboard bench for grid_renderer frames, overlays, start handling and reset
module tb_grid_renderer;
  import starflux_pkg::*;
  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} px_t;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [GRID_W*GRID_H-1:0] g = '0;
  logic [7:0] ux = 8'd200;
  logic [7:0] ex = 8'd200;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot, busy, done;
  px_t sb_q[$];
  px_t sp_q[$];
  int fr_q[$];
  int total = 0;
  int bad = 0;
  int to_cnt = 0;
  bit sb_on = 0;
  bit fin = 0;
  grid_renderer #(.GRID_W(GRID_W), .GRID_H(GRID_H)) dut (
    .clock(clk), .reset(rst), .start(start), .grid(g),
    .user_x(ux), .enemy_x(ex), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  function automatic void chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endfunction
  task automatic push_frame(input int gap);
    px_t p;
    for (int i = 0; i < GRID_W; i++)
      for (int j = 0; j < GRID_H; j++) begin
        p = px_t'{8'(i), 7'(j), COL_BLACK};
        foreach (sp_q[k]) if (sp_q[k].x == 8'(i) && sp_q[k].y == 7'(j)) p.c = sp_q[k].c;
        sb_q.push_back(p);
      end
    fr_q.push_back(gap);
    sp_q.delete();
  endtask
  task automatic wait_busy(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) return;
    end
    to_cnt++;
  endtask
  task automatic wait_done(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) return;
    end
    to_cnt++;
  endtask
  int cyc = 0;
  int f_rise = 0;
  int f_busy = 0;
  int f_plots = 0;
  int f_loads = 0;
  int l_done = -100000;
  bit p_rst = 0;
  bit p_busy = 0;
  bit p_plot = 0;
  bit lxv = 0;
  logic [7:0] lx = 0;
  px_t e;
  // monitor: pops expected pixels on every plot and frame records on every done
  always @(negedge clk) begin
    cyc++;
    if (p_rst) begin
      chk("rst_plot", int'(plot), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_colour", int'(colour), 0);
    end
    if (busy && !p_busy) begin
      f_rise = cyc;
      f_busy = 0;
      f_plots = 0;
      f_loads = 0;
      lxv = 0;
      if (fr_q.size() > 0 && fr_q[0] >= 0) chk("start_gap", cyc - l_done, fr_q[0]);
    end
    if (busy) f_busy++;
    if (busy && !plot && !done) f_loads++;
    if (plot) begin
      if (f_plots == 0) chk("first_plot_lat", cyc - f_rise, 1);
      f_plots++;
      if (lxv && x != lx) begin
        chk("x_step", int'(x), int'(lx) + 1);
        chk("x_after_load", int'(p_plot), 0);
      end
      lx = x;
      lxv = 1;
      if (sb_on) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb_q.pop_front();
          total++;
          if (x != e.x || y != e.y || colour != e.c) begin
            bad++;
            $display("FAIL pix: got (%0d,%0d) c=%b want (%0d,%0d) c=%b", x, y, colour, e.x, e.y, e.c);
          end
        end
      end
    end
    if (done) begin
      if (fr_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        void'(fr_q.pop_front());
        chk("frame_plots", f_plots, 19200);
        chk("frame_loads", f_loads, 160);
        chk("frame_len", cyc - f_rise, 19360);
        chk("busy_cycles", f_busy, 19361);
      end
      l_done = cyc;
    end
    p_rst = rst;
    p_busy = busy;
    p_plot = plot;
    if (fin) begin
      chk("sb_left", sb_q.size(), 0);
      chk("frames_left", fr_q.size(), 0);
      chk("timeouts", to_cnt, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end
  // stimulus: held-start frame pair, aborted frame, fresh frame after reset
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    push_frame(-1);
    sp_q.push_back(px_t'{8'd5, 7'd37, COL_SHOT});
    sp_q.push_back(px_t'{8'd10, 7'd119, COL_PLAYER});
    sp_q.push_back(px_t'{8'd150, 7'd0, COL_ENEMY});
    push_frame(2);
    sb_on = 1;
    @(posedge clk);
    #1 start = 1;
    wait_busy(10);
    repeat (5000) @(posedge clk);
    #1 ux = 8'd10;
    ex = 8'd150;
    wait_done(20000);
    g[120*5+37] = 1'b1;
    g[120*10+119] = 1'b1;
    g[120*150] = 1'b1;
    wait_busy(10);
    start = 0;
    wait_done(20000);
    repeat (5) @(posedge clk);
    #1 sb_on = 0;
    g = '0;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_busy(10);
    repeat (5000) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    repeat (200) @(posedge clk);
    #1 g[0] = 1'b1;
    ux = 8'd0;
    ex = 8'd159;
    sp_q.push_back(px_t'{8'd0, 7'd0, COL_SHOT});
    sp_q.push_back(px_t'{8'd0, 7'd119, COL_PLAYER});
    sp_q.push_back(px_t'{8'd159, 7'd0, COL_ENEMY});
    push_frame(-1);
    sb_on = 1;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_done(20000);
    repeat (3) @(posedge clk);
    fin = 1;
  end
endmodule
